// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory access unit.
package mem_access_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    // Access size encodings carried by mem_accessSize; 2'b11 is illegal.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // FSM state encoding, kept as plain constants for legacy tooling.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    // Byte enables for an aligned access of the given size.
    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [1:0] addr);
        logic [BE_W-1:0] be;
        be = '0;
        case (size)
            SIZE_BYTE: be = BE_W'(4'b0001 << addr);
            SIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = '0;
        endcase
        return be;
    endfunction

    // Replicate the low store bits across every lane they could land in.
    function automatic logic [XLEN-1:0] store_lanes(input logic [1:0]      size,
                                                    input logic [XLEN-1:0] sd);
        logic [XLEN-1:0] wd;
        case (size)
            SIZE_BYTE: wd = {4{sd[7:0]}};
            SIZE_HALF: wd = {2{sd[15:0]}};
            default:   wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Selects the addressed lane of a load word and sign- or zero-extends it.
module mem_load_formatter
    import mem_access_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [1:0]      size_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        data_o    = rdata_i;
        case (addr_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            SIZE_HALF: data_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a req/ready data-memory port.
// Optional bus timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic            mem_memRead,
    input  logic            mem_memWrite,
    input  logic [1:0]      mem_accessSize,
    input  logic            mem_signedLoad,
    input  logic [XLEN-1:0] mem_address,
    input  logic [XLEN-1:0] mem_storeData,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_byteEnable,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_memoryData,
    output logic            mem_stall,
    output logic            mem_misaligned,
    output logic            mem_busError
);

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            access_c;
    logic            is_store_c;
    logic            misalign_c;
    logic            issue_c;
    logic [XLEN-1:0] load_data_c;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     bus_err_q, bus_err_d;
`else
    localparam int unsigned cfg_unused = TIMEOUT_CYCLES + TIMEOUT_WIDTH;
`endif

    // Access decode; a read-and-write instruction is handled as a read.
    always_comb begin
        access_c   = mem_valid & (mem_memRead | mem_memWrite);
        is_store_c = mem_memWrite & ~mem_memRead;
        misalign_c = access_c & ((mem_accessSize == 2'b11) |
                                 ((mem_accessSize == SIZE_HALF) & mem_address[0]) |
                                 ((mem_accessSize == SIZE_WORD) & (mem_address[1:0] != 2'b00)));
        issue_c    = (state_q == IDLE) & access_c & ~misalign_c;
    end

    mem_load_formatter u_fmt (
        .rdata_i  (dmem_rdata),
        .addr_i   (mem_address[1:0]),
        .size_i   (mem_accessSize),
        .signed_i (mem_signedLoad),
        .data_o   (load_data_c)
    );

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        data_d  = data_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (issue_c) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store_c;
                    addr_d  = {mem_address[XLEN-1:2], 2'b00};
                    wdata_d = store_lanes(mem_accessSize, mem_storeData);
                    be_d    = byte_enable(mem_accessSize, mem_address[1:0]);
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        data_d = load_data_c;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    req_d     = 1'b0;
                    data_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
`endif
            end
            // Inputs still show the finished instruction, so never issue here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            data_q  <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            data_q  <= data_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    // Port mapping; stall and misaligned are combinational by design.
    always_comb begin
        dmem_req        = req_q;
        dmem_we         = we_q;
        dmem_addr       = addr_q;
        dmem_wdata      = wdata_q;
        dmem_byteEnable = be_q;
        mem_memoryData  = data_q;
        mem_stall       = issue_c | (state_q == BUSY);
        mem_misaligned  = (state_q == IDLE) & misalign_c;
`ifdef MEM_ACCESS_TIMEOUT_EN
        mem_busError    = bus_err_q;
`else
        mem_busError    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, mem_memRead, mem_memWrite, mem_signedLoad;
    logic [1:0]  mem_accessSize;
    logic [31:0] mem_address, mem_storeData;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_memoryData;
    logic [3:0]  dmem_byteEnable;
    logic        mem_stall, mem_misaligned, mem_busError;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_memRead     (mem_memRead),
        .mem_memWrite    (mem_memWrite),
        .mem_accessSize  (mem_accessSize),
        .mem_signedLoad  (mem_signedLoad),
        .mem_address     (mem_address),
        .mem_storeData   (mem_storeData),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_byteEnable (dmem_byteEnable),
        .dmem_ready      (dmem_ready),
        .dmem_rdata      (dmem_rdata),
        .mem_memoryData  (mem_memoryData),
        .mem_stall       (mem_stall),
        .mem_misaligned  (mem_misaligned),
        .mem_busError    (mem_busError)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          delay;
        logic        exp_mis;
        int          exp_stalls;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_valid = 1'b0; mem_memRead = 1'b0; mem_memWrite = 1'b0;
        mem_accessSize = 2'b00; mem_signedLoad = 1'b0;
        mem_address = 32'h0; mem_storeData = 32'h0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Starts at posedge+1 in IDLE; ends in DONE (issued) or the same IDLE cycle.
    task automatic do_access(input vec_t v, input int idx);
        int stalls;
        int busy;
        int guard;
        stalls = 0; busy = 0; guard = 0;
        mem_valid = v.valid; mem_memRead = v.rd; mem_memWrite = v.wr;
        mem_accessSize = v.size; mem_signedLoad = v.sgn;
        mem_address = v.addr; mem_storeData = v.sd;
        dmem_rdata = v.rdata; dmem_ready = 1'b0;
        #1;
        chk($sformatf("v%0d_misaligned", idx), 32'(mem_misaligned), 32'(v.exp_mis));
        while (mem_stall && guard < 64) begin
            stalls++; guard++;
            @(posedge clock); #1;
            if (mem_stall) begin
                if (busy == 0) begin
                    chk($sformatf("v%0d_req", idx),   32'(dmem_req), 32'd1);
                    chk($sformatf("v%0d_we", idx),    32'(dmem_we), 32'(v.exp_we));
                    chk($sformatf("v%0d_addr", idx),  dmem_addr, v.exp_addr);
                    chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
                    chk($sformatf("v%0d_be", idx),    32'(dmem_byteEnable), 32'(v.exp_be));
                end
                dmem_ready = (busy >= v.delay);
                busy++;
            end else begin
                dmem_ready = 1'b0;
            end
        end
        if (guard >= 64) begin
            checks++; errors++;
            $display("FAIL v%0d_stall_bound actual=%0d required<64", idx, guard);
        end
        chk($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(v.exp_stalls));
        chk($sformatf("v%0d_req_low", idx), 32'(dmem_req), 32'd0);
        chk($sformatf("v%0d_data", idx), mem_memoryData, v.exp_data);
    endtask

    initial begin
        vec_t va, vb;
        //           vld rd wr size   sgn addr          sd            rdata        dly mis stl we exp_addr      exp_wdata     be       exp_data
        vecs[0]  = '{1, 1, 0, 2'b00, 1, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 0, 2, 0, 32'h0000_1000, 32'h0,        4'b1000, 32'hFFFF_FF80};
        vecs[1]  = '{1, 0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 0, 0, 2, 1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 32'hFFFF_FF80};
        vecs[2]  = '{1, 1, 0, 2'b10, 0, 32'h0000_3001, 32'h0,        32'h0,         0, 1, 0, 0, 32'h0,        32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[3]  = '{1, 1, 0, 2'b11, 0, 32'h0000_3000, 32'h0,        32'h0,         0, 1, 0, 0, 32'h0,        32'h0,        4'b0000, 32'hFFFF_FF80};
        vecs[4]  = '{1, 1, 0, 2'b01, 0, 32'h0000_4002, 32'h0,        32'hA5A5_1234, 5, 0, 7, 0, 32'h0000_4000, 32'h0,        4'b1100, 32'h0000_A5A5};
        vecs[5]  = '{1, 1, 0, 2'b00, 0, 32'h0000_5001, 32'h0,        32'h1234_F1AB, 1, 0, 3, 0, 32'h0000_5000, 32'h0,        4'b0010, 32'h0000_00F1};
        vecs[6]  = '{1, 1, 0, 2'b01, 1, 32'h0000_6000, 32'h0,        32'h0000_8001, 0, 0, 2, 0, 32'h0000_6000, 32'h0,        4'b0011, 32'hFFFF_8001};
        vecs[7]  = '{1, 1, 0, 2'b10, 0, 32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 2, 0, 4, 0, 32'h0000_7000, 32'h0,        4'b1111, 32'hDEAD_BEEF};
        vecs[8]  = '{1, 0, 1, 2'b00, 0, 32'h0000_8002, 32'h1234_56AB, 32'hFFFF_FFFF, 0, 0, 2, 1, 32'h0000_8000, 32'hABAB_ABAB, 4'b0100, 32'hDEAD_BEEF};
        vecs[9]  = '{1, 0, 1, 2'b10, 0, 32'h0000_9000, 32'hCAFE_F00D, 32'h0,         3, 0, 5, 1, 32'h0000_9000, 32'hCAFE_F00D, 4'b1111, 32'hDEAD_BEEF};
        vecs[10] = '{1, 0, 0, 2'b10, 0, 32'h0000_1234, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'hDEAD_BEEF};
        vecs[11] = '{0, 1, 0, 2'b10, 0, 32'h0000_3001, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'hDEAD_BEEF};
        vecs[12] = '{1, 1, 1, 2'b10, 0, 32'h0000_A000, 32'h7777_7777, 32'h0BAD_F00D, 0, 0, 2, 0, 32'h0000_A000, 32'h7777_7777, 4'b1111, 32'h0BAD_F00D};
        vecs[13] = '{1, 1, 0, 2'b01, 1, 32'h0000_B001, 32'h0,        32'h0,         0, 1, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0BAD_F00D};

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_we",    32'(dmem_we), 32'd0);
        chk("rst_addr",  dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_be",    32'(dmem_byteEnable), 32'd0);
        chk("rst_data",  mem_memoryData, 32'h0);
        chk("rst_buserr", 32'(mem_busError), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);

        // Table vectors, each followed by one idle cycle
        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i], i);
            drive_idle();
            @(posedge clock); #1;
            chk($sformatf("v%0d_after_req", i), 32'(dmem_req), 32'd0);
        end

        // Ready outside BUSY is ignored
        dmem_ready = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clock); #1;
        chk("stray_ready_data", mem_memoryData, 32'h0BAD_F00D);
        chk("stray_ready_req", 32'(dmem_req), 32'd0);
        dmem_ready = 1'b0;

        // Back-to-back loads: DONE must not issue, next IDLE must
        va = '{1, 1, 0, 2'b10, 0, 32'h0000_E000, 32'h0, 32'h0102_0304, 0, 0, 2, 0, 32'h0000_E000, 32'h0, 4'b1111, 32'h0102_0304};
        vb = '{1, 1, 0, 2'b00, 1, 32'h0000_E001, 32'h0, 32'h0000_8000, 0, 0, 2, 0, 32'h0000_E000, 32'h0, 4'b0010, 32'hFFFF_FF80};
        do_access(va, 20);
        mem_address = vb.addr; mem_accessSize = vb.size; mem_signedLoad = vb.sgn;
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("b2b_done_stall", 32'(mem_stall), 32'd0);
        @(posedge clock); #1;
        chk("b2b_idle_req", 32'(dmem_req), 32'd0);
        chk("b2b_idle_stall", 32'(mem_stall), 32'd1);
        chk("b2b_idle_data", mem_memoryData, 32'h0102_0304);
        do_access(vb, 21);
        drive_idle();
        @(posedge clock); #1;

        // Reset while BUSY, then a late ready
        mem_valid = 1'b1; mem_memRead = 1'b1; mem_accessSize = 2'b10;
        mem_address = 32'h0000_C000; dmem_rdata = 32'h1111_1111;
        @(posedge clock); #1;
        chk("rstb_busy_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        drive_idle();
        chk("rstb_req", 32'(dmem_req), 32'd0);
        chk("rstb_data", mem_memoryData, 32'h0);
        dmem_ready = 1'b1; dmem_rdata = 32'h1111_1111;
        @(posedge clock); #1;
        dmem_ready = 1'b0;
        chk("rstb_late_data", mem_memoryData, 32'h0);
        chk("rstb_late_req", 32'(dmem_req), 32'd0);
        chk("rstb_late_stall", 32'(mem_stall), 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        begin
            int busy_cnt;
            va = '{1, 1, 0, 2'b10, 0, 32'h0000_D000, 32'h0, 32'h55AA_55AA, 0, 0, 2, 0, 32'h0000_D000, 32'h0, 4'b1111, 32'h55AA_55AA};
            do_access(va, 30);
            drive_idle();
            @(posedge clock); #1;
            mem_valid = 1'b1; mem_memRead = 1'b1; mem_accessSize = 2'b10;
            mem_address = 32'h0000_D000;
            @(posedge clock); #1;
            busy_cnt = 0;
            while (dmem_req && busy_cnt < 20) begin
                chk("to_busy_buserr", 32'(mem_busError), 32'd0);
                busy_cnt++;
                @(posedge clock); #1;
            end
            chk("to_busy_cycles", 32'(busy_cnt), 32'd4);
            chk("to_buserr", 32'(mem_busError), 32'd1);
            chk("to_data", mem_memoryData, 32'h0);
            chk("to_stall", 32'(mem_stall), 32'd0);
            drive_idle();
            @(posedge clock); #1;
            chk("to_buserr_clear", 32'(mem_busError), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access engine, between the EX/MEM pipeline register and the MEM/WB register. Converts a load or store from the MEM stage into a request/ready transaction on the data-memory port. Generates byte enables and store-lane replication, and sign- or zero-extends load data. Holds the pipeline via mem_stall until the access completes; mem_memoryData feeds the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without dmem_ready before a bus error (used only with the optional feature)
TIMEOUT_WIDTH, 8, width of the timeout counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
mem_valid  in  1  MEM stage holds a live instruction
mem_memRead  in  1  instruction is a load
mem_memWrite  in  1  instruction is a store
mem_accessSize  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_signedLoad  in  1  1 = sign-extend, 0 = zero-extend
mem_address  in  32  byte address from the ALU
mem_storeData  in  32  rt value; low bits hold the store data
dmem_req  out  1  memory request, registered
dmem_we  out  1  write enable, registered
dmem_addr  out  32  word address {mem_address[31:2],2'b00}, registered
dmem_wdata  out  32  lane-replicated store data, registered
dmem_byteEnable  out  4  byte enables, registered
dmem_ready  in  1  memory completes the current request this cycle
dmem_rdata  in  32  read data, valid when dmem_ready=1
mem_memoryData  out  32  formatted load result, registered
mem_stall  out  1  freeze upstream stages, combinational
mem_misaligned  out  1  alignment or size fault, combinational
mem_busError  out  1  timeout fault, registered (optional feature)

Behaviour:
- Reset values: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_byteEnable=0; mem_memoryData=0; mem_busError=0; timeout counter=0.
- access = mem_valid & (mem_memRead | mem_memWrite). If both mem_memRead and mem_memWrite are set, the access is treated as a read.
- misaligned = access & (size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0)). mem_misaligned is high only in IDLE. A misaligned access issues no request, raises no stall, and leaves mem_memoryData unchanged.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Store data: byte = {4{sd[7:0]}}; half = {2{sd[15:0]}}; word = sd.
- Load data: byte lane addr[1:0], half lane addr[1]; the lane is extended per mem_signedLoad.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on access & !misaligned, register the request (dmem_req=1) and go to BUSY. mem_stall=1 in this cycle.
- BUSY: dmem_req held high and mem_stall=1.
  - On dmem_ready: dmem_req drops to 0 at the edge. A load captures the formatted rdata into mem_memoryData; a store leaves it unchanged. Go to DONE.
- DONE: mem_stall=0, so the pipeline advances at the end of this cycle. No request may be issued because the inputs still show the same instruction. Go to IDLE unconditionally.
- Latency: minimum 3 cycles per access (IDLE, BUSY with immediate ready, DONE). A non-memory instruction passes in 1 cycle with no stall.
- dmem_ready outside BUSY is ignored.
- Back-to-back loads: the second load is detected in the IDLE cycle that follows DONE.
- Reset mid-access: return to IDLE and drop dmem_req at the reset edge. A late dmem_ready arriving after reset is ignored.
- mem_memoryData changes only on load completion or reset.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle without dmem_ready.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, set mem_memoryData=0, assert mem_busError for exactly the DONE cycle, then go to DONE.
- Undefined: BUSY waits indefinitely and mem_busError is tied to 0.

Decomposition:
- Package mem_access_pkg:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - FSM state type {IDLE, BUSY, DONE}.
- One sub-module: mem_load_formatter, combinational lane select plus extension (inputs rdata, addr[1:0], size, signed).

Test Plan:
1. lb at 0x1003, rdata=0x80112233, ready on the first BUSY cycle -> byteEnable=1000, mem_stall high for exactly 2 cycles, mem_memoryData=0xFFFFFF80.
2. sh at 0x2002, storeData=0x0000BEEF -> dmem_addr=0x2000, wdata=0xBEEFBEEF, byteEnable=1100, dmem_we=1; mem_memoryData unchanged.
3. lw at 0x3001 -> mem_misaligned=1, dmem_req stays 0, mem_stall=0. Repeat with size=11 at 0x3000 -> same response.
4. lhu at 0x4002, ready delayed 5 cycles, rdata=0xA5A51234 -> 7 stall cycles, mem_memoryData=0x0000A5A5.
5. reset asserted in BUSY, then ready pulsed -> IDLE with dmem_req=0, mem_memoryData=0; the late ready is ignored.
6. With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready never asserted -> dmem_req drops after 4 BUSY cycles, mem_busError=1 for 1 cycle, mem_memoryData=0.
